// File: rtl/score_fill_ctrl.sv
// -----------------------------------------------------------------------------
// score_fill_ctrl
//   Sequencer that fills a Needleman-Wunsch score matrix held in a single-port
//   score RAM with a synchronous read.
//   1. Writes the gap-penalty border in 2N+1 cycles: row 0, then column 0.
//   2. Visits every interior cell in row-major order, 5 cycles per cell:
//      read diagonal, read up, read left, combine, write the maximum back.
//
// Ports
//   clk          single rising-edge clock
//   rst          asynchronous active-low reset
//   start        fill request, accepted only while idle
//   match        1 when the residues at (row_idx, col_idx) are equal
//   row_idx      current cell row i
//   col_idx      current cell column j
//   ram_addr     score RAM address, i*(N+1)+j
//   ram_we       score RAM write enable
//   ram_wdata    score RAM write data
//   ram_rdata    score RAM read data, valid one cycle after its address
//   busy         high from the cycle after start is accepted through DONE
//   done         one-cycle completion pulse
//   final_score  H(N,N) of the most recent completed fill
//
// Every output comes straight from a register, so the values for a state are
// computed one cycle early from the next-state logic.
// -----------------------------------------------------------------------------

// Protocol checks for the sequencer: write enable legality and pulse shapes.
module score_fill_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic we_legal,
    input logic ram_we,
    input logic busy,
    input logic done
);

    // A RAM write may only appear while initialising or writing a cell.
    a_we_legal : assert property (@(posedge clk) disable iff (!rst) ram_we |-> we_legal);

    // done is a single-cycle pulse.
    a_done_pulse : assert property (@(posedge clk) disable iff (!rst) done |=> !done);

    // done is only ever raised while the block reports busy.
    a_done_busy : assert property (@(posedge clk) disable iff (!rst) done |-> busy);

endmodule

module score_fill_ctrl #(
    parameter int N        = 8,
    parameter int ADDR_W   = 7,
    parameter int SCORE_W  = 8,
    parameter int MATCH    = 1,
    parameter int MISMATCH = -1,
    parameter int GAP      = -1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               match,
    output logic [ADDR_W-1:0]  row_idx,
    output logic [ADDR_W-1:0]  col_idx,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [SCORE_W-1:0] ram_wdata,
    input  logic [SCORE_W-1:0] ram_rdata,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] final_score
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INIT    = 3'd1;
    localparam logic [2:0] ST_RD_DIAG = 3'd2;
    localparam logic [2:0] ST_RD_UP   = 3'd3;
    localparam logic [2:0] ST_RD_LEFT = 3'd4;
    localparam logic [2:0] ST_CALC    = 3'd5;
    localparam logic [2:0] ST_WR      = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    localparam logic [ADDR_W-1:0] ZERO_A      = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A       = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] N_A         = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] NP1_A       = ADDR_W'(N + 1);
    localparam logic [ADDR_W-1:0] INIT_LAST_A = ADDR_W'(2 * N + 1);

    localparam logic signed [SCORE_W-1:0] ZERO_S     = {SCORE_W{1'b0}};
    localparam logic signed [SCORE_W-1:0] MATCH_S    = SCORE_W'(MATCH);
    localparam logic signed [SCORE_W-1:0] MISMATCH_S = SCORE_W'(MISMATCH);
    localparam logic signed [SCORE_W-1:0] GAP_S      = SCORE_W'(GAP);

    // Linear RAM address of matrix cell (i, j).
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ADDR_W-1:0] i,
                                                    input logic [ADDR_W-1:0] j);
        logic [2*ADDR_W-1:0] prod_s;
        prod_s = {{ADDR_W{1'b0}}, i} * {{ADDR_W{1'b0}}, NP1_A};
        return prod_s[ADDR_W-1:0] + j;
    endfunction

    // Border write k: k=0..N walks row 0, k=N+1..2N walks column 0 from row 1.
    function automatic logic [ADDR_W-1:0] init_addr(input logic [ADDR_W-1:0] k);
        logic [ADDR_W-1:0] a_s;
        if (k <= N_A) begin
            a_s = k;
        end else begin
            a_s = cell_addr(k - N_A, ZERO_A);
        end
        return a_s;
    endfunction

    // Border value for write k: distance from (0,0) times the gap penalty.
    // Only the low SCORE_W bits of the product matter, so sign handling of the
    // multiply does not change the result.
    function automatic logic [SCORE_W-1:0] init_data(input logic [ADDR_W-1:0] k);
        logic [ADDR_W-1:0]  idx_s;
        logic [SCORE_W-1:0] idx_w_s;
        if (k <= N_A) begin
            idx_s = k;
        end else begin
            idx_s = k - N_A;
        end
        idx_w_s = SCORE_W'(idx_s);
        return idx_w_s * GAP_S;
    endfunction

    // Signed maximum of three candidate scores.
    function automatic logic signed [SCORE_W-1:0] max3(input logic signed [SCORE_W-1:0] a,
                                                       input logic signed [SCORE_W-1:0] b,
                                                       input logic signed [SCORE_W-1:0] c);
        logic signed [SCORE_W-1:0] m_s;
        m_s = (a >= b) ? a : b;
        m_s = (c > m_s) ? c : m_s;
        return m_s;
    endfunction

    logic [2:0]                state_r, state_nxt_s;
    logic [ADDR_W-1:0]         row_r, row_nxt_s;
    logic [ADDR_W-1:0]         col_r, col_nxt_s;
    logic [ADDR_W-1:0]         k_r, k_nxt_s;
    logic [ADDR_W-1:0]         addr_r, addr_nxt_s;
    logic                      we_r, we_nxt_s;
    logic [SCORE_W-1:0]        wdata_r, wdata_nxt_s;
    logic signed [SCORE_W-1:0] d_r, d_nxt_s;
    logic signed [SCORE_W-1:0] u_r, u_nxt_s;
    logic                      busy_r, busy_nxt_s;
    logic                      done_r, done_nxt_s;
    logic [SCORE_W-1:0]        final_r, final_nxt_s;

    logic signed [SCORE_W-1:0] diag_s;
    logic signed [SCORE_W-1:0] up_s;
    logic signed [SCORE_W-1:0] left_s;
    logic signed [SCORE_W-1:0] score_s;
    logic                      we_legal_s;

    // Candidate scores of the current cell; in CALC ram_rdata holds the left neighbour.
    always_comb begin
        diag_s  = d_r + (match ? MATCH_S : MISMATCH_S);
        up_s    = u_r + GAP_S;
        left_s  = $signed(ram_rdata) + GAP_S;
        score_s = max3(diag_s, up_s, left_s);
    end

    // Next-state and next-output logic for the fill sequencer.
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_r;
        col_nxt_s   = col_r;
        k_nxt_s     = k_r;
        addr_nxt_s  = addr_r;
        we_nxt_s    = 1'b0;
        wdata_nxt_s = wdata_r;
        d_nxt_s     = d_r;
        u_nxt_s     = u_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        final_nxt_s = final_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    // First border write (0,0)=0 is issued in the first INIT cycle.
                    state_nxt_s = ST_INIT;
                    row_nxt_s   = ZERO_A;
                    col_nxt_s   = ZERO_A;
                    k_nxt_s     = ONE_A;
                    addr_nxt_s  = ZERO_A;
                    wdata_nxt_s = ZERO_S;
                    we_nxt_s    = 1'b1;
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_INIT: begin
                // k_r is the index of the write for the next cycle.
                if (k_r == INIT_LAST_A) begin
                    state_nxt_s = ST_RD_DIAG;
                    row_nxt_s   = ONE_A;
                    col_nxt_s   = ONE_A;
                    addr_nxt_s  = cell_addr(ZERO_A, ZERO_A);
                end else begin
                    we_nxt_s    = 1'b1;
                    addr_nxt_s  = init_addr(k_r);
                    wdata_nxt_s = init_data(k_r);
                    k_nxt_s     = k_r + ONE_A;
                end
            end

            ST_RD_DIAG: begin
                state_nxt_s = ST_RD_UP;
                addr_nxt_s  = cell_addr(row_r - ONE_A, col_r);
            end

            ST_RD_UP: begin
                state_nxt_s = ST_RD_LEFT;
                d_nxt_s     = $signed(ram_rdata);
                addr_nxt_s  = cell_addr(row_r, col_r - ONE_A);
            end

            ST_RD_LEFT: begin
                state_nxt_s = ST_CALC;
                u_nxt_s     = $signed(ram_rdata);
                addr_nxt_s  = cell_addr(row_r, col_r);
            end

            ST_CALC: begin
                state_nxt_s = ST_WR;
                we_nxt_s    = 1'b1;
                addr_nxt_s  = cell_addr(row_r, col_r);
                wdata_nxt_s = score_s;
            end

            ST_WR: begin
                // The next cell's diagonal read address is prepared here.
                if (col_r < N_A) begin
                    state_nxt_s = ST_RD_DIAG;
                    col_nxt_s   = col_r + ONE_A;
                    addr_nxt_s  = cell_addr(row_r - ONE_A, col_r);
                end else if (row_r < N_A) begin
                    state_nxt_s = ST_RD_DIAG;
                    row_nxt_s   = row_r + ONE_A;
                    col_nxt_s   = ONE_A;
                    addr_nxt_s  = cell_addr(row_r, ZERO_A);
                end else begin
                    state_nxt_s = ST_DONE;
                    final_nxt_s = wdata_r;
                    done_nxt_s  = 1'b1;
                end
            end

            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end

            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            row_r   <= ZERO_A;
            col_r   <= ZERO_A;
            k_r     <= ZERO_A;
            addr_r  <= ZERO_A;
            we_r    <= 1'b0;
            wdata_r <= ZERO_S;
            d_r     <= ZERO_S;
            u_r     <= ZERO_S;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            final_r <= ZERO_S;
        end else begin
            state_r <= state_nxt_s;
            row_r   <= row_nxt_s;
            col_r   <= col_nxt_s;
            k_r     <= k_nxt_s;
            addr_r  <= addr_nxt_s;
            we_r    <= we_nxt_s;
            wdata_r <= wdata_nxt_s;
            d_r     <= d_nxt_s;
            u_r     <= u_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            final_r <= final_nxt_s;
        end
    end

    assign row_idx     = row_r;
    assign col_idx     = col_r;
    assign ram_addr    = addr_r;
    assign ram_we      = we_r;
    assign ram_wdata   = wdata_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign final_score = final_r;

    assign we_legal_s = (state_r == ST_INIT) || (state_r == ST_WR);

    score_fill_ctrl_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .we_legal (we_legal_s),
        .ram_we   (we_r),
        .busy     (busy_r),
        .done     (done_r)
    );

endmodule

// File: tb/tb_score_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_fill_ctrl
//   Two instances share clock and reset: instance 0 with N=2, instance 1 with
//   N=8. Each has its own synchronous-read score RAM model. The match input is
//   derived from random residue strings (or forced to all-1 / all-0), and a
//   plain dynamic-programming model gives the expected matrix.
// -----------------------------------------------------------------------------
module tb_score_fill_ctrl;

    localparam int GAP      = -1;
    localparam int MATCH    = 1;
    localparam int MISMATCH = -1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       start_v [2];
    logic       match_v [2];
    logic [6:0] row_w   [2];
    logic [6:0] col_w   [2];
    logic [6:0] addr_w  [2];
    logic       we_w    [2];
    logic [7:0] wdata_w [2];
    logic [7:0] rdata_v [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic [7:0] final_w [2];

    logic [7:0]  mem0 [128];
    logic [7:0]  mem1 [128];
    int          mode_v [2];
    logic [15:0] seq_a;
    logic [15:0] seq_b;

    int total = 0;
    int bad   = 0;
    int exp_h [0:8][0:8];

    int w_addr_q[$];
    int w_data_q[$];
    int w_cyc_q[$];
    int w_row_q[$];
    int w_col_q[$];
    int done_cyc, done_cnt, busy_first, busy_last;

    always #5 clk = ~clk;

    score_fill_ctrl #(.N(2), .ADDR_W(7), .SCORE_W(8), .MATCH(MATCH), .MISMATCH(MISMATCH), .GAP(GAP)) u_dut_n2 (
        .clk(clk), .rst(rst), .start(start_v[0]), .match(match_v[0]),
        .row_idx(row_w[0]), .col_idx(col_w[0]), .ram_addr(addr_w[0]), .ram_we(we_w[0]),
        .ram_wdata(wdata_w[0]), .ram_rdata(rdata_v[0]), .busy(busy_w[0]), .done(done_w[0]),
        .final_score(final_w[0])
    );

    score_fill_ctrl #(.N(8), .ADDR_W(7), .SCORE_W(8), .MATCH(MATCH), .MISMATCH(MISMATCH), .GAP(GAP)) u_dut_n8 (
        .clk(clk), .rst(rst), .start(start_v[1]), .match(match_v[1]),
        .row_idx(row_w[1]), .col_idx(col_w[1]), .ram_addr(addr_w[1]), .ram_we(we_w[1]),
        .ram_wdata(wdata_w[1]), .ram_rdata(rdata_v[1]), .busy(busy_w[1]), .done(done_w[1]),
        .final_score(final_w[1])
    );

    // Score RAM models: synchronous read, data valid the cycle after the address.
    always @(posedge clk) begin
        if (we_w[0]) mem0[addr_w[0]] <= wdata_w[0];
        rdata_v[0] <= mem0[addr_w[0]];
    end

    always @(posedge clk) begin
        if (we_w[1]) mem1[addr_w[1]] <= wdata_w[1];
        rdata_v[1] <= mem1[addr_w[1]];
    end

    // Residue comparison seen by the DUT for its current (row, col).
    function automatic logic match_fn(input int mode, input logic [6:0] r, input logic [6:0] c,
                                      input logic [15:0] sa, input logic [15:0] sb);
        int ri;
        int ci;
        ri = int'(r);
        ci = int'(c);
        if (mode == 1) return 1'b1;
        else if (mode == 2) return 1'b0;
        else if (ri < 1 || ci < 1 || ri > 8 || ci > 8) return 1'b0;
        else return sa[2*(ri-1) +: 2] == sb[2*(ci-1) +: 2];
    endfunction

    assign match_v[0] = match_fn(mode_v[0], row_w[0], col_w[0], seq_a, seq_b);
    assign match_v[1] = match_fn(mode_v[1], row_w[1], col_w[1], seq_a, seq_b);

    function automatic int mem_rd(input int sel, input int a);
        if (sel == 0) return int'($signed(mem0[a]));
        else return int'($signed(mem1[a]));
    endfunction

    // Textbook Needleman-Wunsch recurrence over the chosen match rule.
    task automatic build_model(input int n, input int mode);
        int eq;
        int best;
        for (int i = 0; i <= n; i++) exp_h[i][0] = i * GAP;
        for (int j = 0; j <= n; j++) exp_h[0][j] = j * GAP;
        for (int i = 1; i <= n; i++) begin
            for (int j = 1; j <= n; j++) begin
                if (mode == 1) eq = 1;
                else if (mode == 2) eq = 0;
                else eq = (seq_a[2*(i-1) +: 2] == seq_b[2*(j-1) +: 2]) ? 1 : 0;
                best = exp_h[i-1][j-1] + ((eq == 1) ? MATCH : MISMATCH);
                if (exp_h[i-1][j] + GAP > best) best = exp_h[i-1][j] + GAP;
                if (exp_h[i][j-1] + GAP > best) best = exp_h[i][j-1] + GAP;
                exp_h[i][j] = best;
            end
        end
    endtask

    // Pulse start, then log writes, busy and done per cycle (cycle 1 = first
    // cycle after the edge that samples start). Optional second start pulse.
    task automatic run_fill(input int sel, input int restart_at, input int budget);
        w_addr_q.delete(); w_data_q.delete(); w_cyc_q.delete(); w_row_q.delete(); w_col_q.delete();
        done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1;
        @(negedge clk); start_v[sel] = 1'b1;
        @(negedge clk); start_v[sel] = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            start_v[sel] = (c == restart_at);
            if (we_w[sel]) begin
                w_addr_q.push_back(int'(addr_w[sel]));
                w_data_q.push_back(int'($signed(wdata_w[sel])));
                w_cyc_q.push_back(c);
                w_row_q.push_back(int'(row_w[sel]));
                w_col_q.push_back(int'(col_w[sel]));
            end
            if (busy_w[sel]) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (done_w[sel]) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc > 0 && c >= done_cyc + 3) break;
            @(negedge clk);
        end
        start_v[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            total++; if (row_w[s] !== 7'd0) begin bad++; $display("FAIL reset_row[%0d]: got %0d want 0", s, row_w[s]); end
            total++; if (col_w[s] !== 7'd0) begin bad++; $display("FAIL reset_col[%0d]: got %0d want 0", s, col_w[s]); end
            total++; if (addr_w[s] !== 7'd0) begin bad++; $display("FAIL reset_addr[%0d]: got %0d want 0", s, addr_w[s]); end
            total++; if (we_w[s] !== 1'b0) begin bad++; $display("FAIL reset_we[%0d]: got %0d want 0", s, we_w[s]); end
            total++; if (wdata_w[s] !== 8'd0) begin bad++; $display("FAIL reset_wdata[%0d]: got %0d want 0", s, wdata_w[s]); end
            total++; if (busy_w[s] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %0d want 0", s, busy_w[s]); end
            total++; if (done_w[s] !== 1'b0) begin bad++; $display("FAIL reset_done[%0d]: got %0d want 0", s, done_w[s]); end
            total++; if (final_w[s] !== 8'd0) begin bad++; $display("FAIL reset_final[%0d]: got %0d want 0", s, final_w[s]); end
        end
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++; if (we_w[0] !== 1'b0 || we_w[1] !== 1'b0) begin bad++; $display("FAIL idle_we cycle %0d: got %0d/%0d want 0/0", c, we_w[0], we_w[1]); end
        end
    endtask

    task automatic test_init_pattern();
        int ea [5] = '{0, 1, 2, 3, 6};
        int ed [5] = '{0, -1, -2, -1, -2};
        mode_v[0] = 1;
        run_fill(0, 0, 60);
        total++;
        if (w_addr_q.size() < 5) begin
            bad++; $display("FAIL init_count: got %0d writes want at least 5", w_addr_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++; if (w_cyc_q[k] !== k + 1) begin bad++; $display("FAIL init_cycle[%0d]: got %0d want %0d", k, w_cyc_q[k], k + 1); end
                total++; if (w_addr_q[k] !== ea[k]) begin bad++; $display("FAIL init_addr[%0d]: got %0d want %0d", k, w_addr_q[k], ea[k]); end
                total++; if (w_data_q[k] !== ed[k]) begin bad++; $display("FAIL init_data[%0d]: got %0d want %0d", k, w_data_q[k], ed[k]); end
            end
        end
    endtask

    task automatic test_all_match();
        mode_v[0] = 1;
        run_fill(0, 0, 60);
        total++; if (done_cyc !== 26) begin bad++; $display("FAIL match_done_cycle: got %0d want 26", done_cyc); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL match_done_count: got %0d want 1", done_cnt); end
        total++; if (busy_first !== 1) begin bad++; $display("FAIL match_busy_rise: got %0d want 1", busy_first); end
        total++; if (busy_last !== 26) begin bad++; $display("FAIL match_busy_fall: got %0d want 26", busy_last); end
        total++; if (mem_rd(0, 4) !== 1) begin bad++; $display("FAIL match_h11: got %0d want 1", mem_rd(0, 4)); end
        total++; if (mem_rd(0, 8) !== 2) begin bad++; $display("FAIL match_h22: got %0d want 2", mem_rd(0, 8)); end
        total++; if ($signed(final_w[0]) !== 8'sd2) begin bad++; $display("FAIL match_final: got %0d want 2", $signed(final_w[0])); end
    endtask

    task automatic test_all_mismatch();
        int ca [4] = '{4, 5, 7, 8};
        int cv [4] = '{-1, -2, -2, -2};
        mode_v[0] = 2;
        run_fill(0, 0, 60);
        for (int k = 0; k < 4; k++) begin
            total++; if (mem_rd(0, ca[k]) !== cv[k]) begin bad++; $display("FAIL mismatch_cell addr %0d: got %0d want %0d", ca[k], mem_rd(0, ca[k]), cv[k]); end
        end
        total++; if ($signed(final_w[0]) !== -8'sd2) begin bad++; $display("FAIL mismatch_final: got %0d want -2", $signed(final_w[0])); end
        total++; if (done_cyc !== 26) begin bad++; $display("FAIL mismatch_done_cycle: got %0d want 26", done_cyc); end
    endtask

    task automatic test_start_while_busy();
        mode_v[0] = 1;
        run_fill(0, 10, 60);
        total++; if (done_cyc !== 26) begin bad++; $display("FAIL busy_start_done_cycle: got %0d want 26", done_cyc); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt); end
        total++; if (w_addr_q.size() !== 9) begin bad++; $display("FAIL busy_start_writes: got %0d want 9", w_addr_q.size()); end
        total++; if (busy_last !== 26) begin bad++; $display("FAIL busy_start_busy_fall: got %0d want 26", busy_last); end
    endtask

    task automatic test_random();
        int sel, n, nw, m, ei, ej, ea, ed;
        for (int r = 0; r < 6; r++) begin
            sel = r % 2;
            n = (sel == 0) ? 2 : 8;
            seq_a = 16'($urandom);
            seq_b = 16'($urandom);
            mode_v[sel] = 0;
            build_model(n, 0);
            run_fill(sel, 0, 5 * n * n + 2 * n + 20);
            nw = 2 * n + 1 + n * n;
            total++; if (done_cyc !== 2 * n + 2 + 5 * n * n) begin bad++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", r, done_cyc, 2 * n + 2 + 5 * n * n); end
            total++; if (int'($signed(final_w[sel])) !== exp_h[n][n]) begin bad++; $display("FAIL rnd%0d_final: got %0d want %0d", r, $signed(final_w[sel]), exp_h[n][n]); end
            total++;
            if (w_addr_q.size() !== nw) begin
                bad++; $display("FAIL rnd%0d_write_count: got %0d want %0d", r, w_addr_q.size(), nw);
            end else begin
                for (int k = 0; k < nw; k++) begin
                    if (k <= 2 * n) begin
                        ei = (k <= n) ? 0 : k - n;
                        ej = (k <= n) ? k : 0;
                    end else begin
                        m = k - (2 * n + 1);
                        ei = m / n + 1;
                        ej = m % n + 1;
                        total++; if (w_row_q[k] !== ei || w_col_q[k] !== ej) begin bad++; $display("FAIL rnd%0d_idx[%0d]: got (%0d,%0d) want (%0d,%0d)", r, k, w_row_q[k], w_col_q[k], ei, ej); end
                    end
                    ea = ei * (n + 1) + ej;
                    ed = exp_h[ei][ej];
                    total++; if (w_addr_q[k] !== ea || w_data_q[k] !== ed) begin bad++; $display("FAIL rnd%0d_write[%0d]: got %0d/%0d want %0d/%0d", r, k, w_addr_q[k], w_data_q[k], ea, ed); end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        seq_a = 16'($urandom);
        seq_b = 16'($urandom);
        mode_v[1] = 0;
        @(negedge clk); start_v[1] = 1'b1;
        @(negedge clk); start_v[1] = 1'b0;
        repeat (99) @(negedge clk);
        total++; if (busy_w[1] !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %0d want 1", busy_w[1]); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (we_w[1] !== 1'b0) begin bad++; $display("FAIL midrst_we: got %0d want 0", we_w[1]); end
        total++; if (busy_w[1] !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %0d want 0", busy_w[1]); end
        total++; if (row_w[1] !== 7'd0 || col_w[1] !== 7'd0) begin bad++; $display("FAIL midrst_idx: got (%0d,%0d) want (0,0)", row_w[1], col_w[1]); end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (we_w[1] !== 1'b0 || busy_w[1] !== 1'b0) begin bad++; $display("FAIL midrst_idle cycle %0d: got we=%0d busy=%0d want 0/0", c, we_w[1], busy_w[1]); end
        end
        build_model(8, 0);
        run_fill(1, 0, 400);
        total++; if (done_cyc !== 338) begin bad++; $display("FAIL midrst_done_cycle: got %0d want 338", done_cyc); end
        total++; if (int'($signed(final_w[1])) !== exp_h[8][8]) begin bad++; $display("FAIL midrst_final: got %0d want %0d", $signed(final_w[1]), exp_h[8][8]); end
        for (int i = 0; i <= 8; i++) begin
            for (int j = 0; j <= 8; j++) begin
                total++; if (mem_rd(1, i * 9 + j) !== exp_h[i][j]) begin bad++; $display("FAIL midrst_cell(%0d,%0d): got %0d want %0d", i, j, mem_rd(1, i * 9 + j), exp_h[i][j]); end
            end
        end
    endtask

    initial begin
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        mode_v[0] = 1; mode_v[1] = 1;
        seq_a = 16'd0; seq_b = 16'd0;
        test_reset();
        test_init_pattern();
        test_all_match();
        test_all_mismatch();
        test_start_while_busy();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_fill_ctrl.md
# score_fill_ctrl

Sequencer for the Needleman-Wunsch score matrix held in the score RAM. It initialises row 0 and column 0 with gap penalties, then walks every interior cell in row-major order. For each cell it reads the diagonal, up and left neighbours, combines them with the external match flag, and writes the maximum back. It sits between the top-level start/done handshake and the single-port score RAM, and drives the row/column indices consumed by the sequence-compare logic.

## Interface
- N, 8: sequence length; the matrix is (N+1)x(N+1).
- ADDR_W, 7: score RAM address width; must satisfy 2^ADDR_W >= (N+1)^2.
- SCORE_W, 8: signed score width.
- MATCH, 1: signed reward for a diagonal step with match=1.
- MISMATCH, -1: signed penalty for a diagonal step with match=0.
- GAP, -1: signed penalty for an up or left step.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to fill the matrix; sampled only in IDLE.
- match  in  1  1 when seqA[row_idx-1]==seqB[col_idx-1]; sampled in CALC.
- row_idx  out  ADDR_W  current cell row i.
- col_idx  out  ADDR_W  current cell column j.
- ram_addr  out  ADDR_W  score RAM address, computed as i*(N+1)+j of the target cell.
- ram_we  out  1  score RAM write enable.
- ram_wdata  out  SCORE_W  score RAM write data.
- ram_rdata  in  SCORE_W  score RAM read data; synchronous read, valid one cycle after the address.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse at completion.
- final_score  out  SCORE_W  H(N,N), held until the next accepted start.

## Operation
- States: IDLE, INIT, RD_DIAG, RD_UP, RD_LEFT, CALC, WR, DONE.
- IDLE
  - start=1 goes to INIT with init counter k=0.
  - start=0 stays in IDLE.
- INIT
  - Issues one write per cycle, 2N+1 writes, in this order:
    - (0,0) with value 0;
    - (0,j) with value j*GAP, for j=1..N;
    - (i,0) with value i*GAP, for i=1..N.
  - After the last write, goes to RD_DIAG with i=1, j=1.
- RD_DIAG: address (i-1,j-1).
- RD_UP: address (i-1,j); captures ram_rdata as d.
- RD_LEFT: address (i,j-1); captures ram_rdata as u.
- CALC
  - Captures ram_rdata as l.
  - Samples match.
  - Computes s = max(d+(match?MATCH:MISMATCH), u+GAP, l+GAP).
- WR
  - Sets ram_we=1, ram_addr=(i,j), ram_wdata=s.
  - If j<N: j+1, then RD_DIAG.
  - Else if i<N: i+1 and j=1, then RD_DIAG.
  - Else: final_score<=s, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- ram_we is 1 only in INIT and WR.
- row_idx and col_idx are constant across the five states of a cell.
- Arithmetic is signed SCORE_W with no saturation. Parameters must keep |score| <= 2N*max(|GAP|,|MISMATCH|,MATCH) within range.
- start while busy is ignored; no queuing.
- Reset mid-operation: returns to IDLE immediately. RAM contents are left as they are. The next start redoes INIT fully.

## Timing
- Reset values: state=IDLE; row_idx=0, col_idx=0, ram_addr=0, ram_we=0, ram_wdata=0, busy=0, done=0, final_score=0.
- Latency is measured from the edge that samples start (cycle 0):
  - INIT occupies cycles 1..2N+1;
  - the fill occupies 5N^2 cycles, 5 per cell;
  - done is high in cycle 2N+2+5N^2.
- N=8 gives 338 cycles.
- busy is high in cycles 1..2N+2+5N^2 inclusive.
- A new start is accepted in the cycle after DONE at the earliest.

## Test plan
- Reset values: hold rst low, toggle clk -> every output matches its listed reset value; release and idle 10 cycles -> ram_we stays 0.
- Init pattern: N=2, pulse start, log RAM writes in cycles 1..5 -> addr/data 0/0, 1/-1, 2/-2, 3/-1, 6/-2.
- All-match run: N=2, match=1 always -> H(1,1)=1, H(2,2)=2; done pulses in cycle 26; final_score=2; busy falls with done.
- All-mismatch run: N=2, match=0 always -> cells (1,1)..(2,2) = -1, -2, -2, -2; final_score=-2.
- Start while busy: N=2, pulse start again at cycle 10 -> ignored, done still in cycle 26, exactly 9 RAM writes (5 init + 4 cells).
- Reset mid-operation: N=8, assert rst at cycle 100 -> next edge IDLE and ram_we=0; restart -> done 338 cycles after the new start, final_score equals a golden model's result.
